// File: rtl/vga_timing_pkg.sv
// Purpose : shared timing constants, phase encoding and coordinate width for the VGA raster.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: default 640x480@60 timing, phase_e {ACTIVE, FRONT, SYNC, BACK}, COORD_W.
package vga_timing_pkg;

    // Width of every position/segment counter and of the full-resolution coordinates.
    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    // Default 640x480@60 timing (25.175 MHz pixel clock).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose : one raster axis: phase FSM (ACTIVE->FRONT->SYNC->BACK), segment down-counter, position counter.
// Latency : state updates on the clock edge where i_adv is high; o_wrap is combinational from current state.
// Backpressure: none; i_adv low freezes all state.
// Ports   : clk, rst (async, active-high), i_adv (advance), o_phase, o_pos (0..TOTAL-1), o_wrap (last position, advancing).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FP_LEN     = DEF_H_FP,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BP_LEN     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_adv,
    output phase_e             o_phase,
    output logic [COORD_W-1:0] o_pos,
    output logic               o_wrap
);

    localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    generate
        if (ACTIVE_LEN < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_bad_len
            $error("vga_axis_counter: every phase length must be >= 1");
        end
        if (TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_axis_counter: axis total exceeds coordinate range");
        end
    endgenerate

    // Segment reload values: each phase counts length-1 down to 0.
    localparam logic [COORD_W-1:0] LAST_ACTIVE = COORD_W'(ACTIVE_LEN - 1);
    localparam logic [COORD_W-1:0] LAST_FP     = COORD_W'(FP_LEN - 1);
    localparam logic [COORD_W-1:0] LAST_SYNC   = COORD_W'(SYNC_LEN - 1);
    localparam logic [COORD_W-1:0] LAST_BP     = COORD_W'(BP_LEN - 1);
    localparam logic [COORD_W-1:0] LAST_POS    = COORD_W'(TOTAL - 1);

    phase_e             r_phase;
    logic [COORD_W-1:0] r_seg;
    logic [COORD_W-1:0] r_pos;

    phase_e             w_phase_nxt;
    logic [COORD_W-1:0] w_seg_nxt;
    logic [COORD_W-1:0] w_pos_nxt;
    logic               w_seg_done;

    // State register. Reset enters ACTIVE with the segment preloaded so ACTIVE
    // lasts its full length from the first advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= ACTIVE;
            r_seg   <= LAST_ACTIVE;
            r_pos   <= '0;
        end else if (i_adv) begin
            r_phase <= w_phase_nxt;
            r_seg   <= w_seg_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_seg_done  = (r_seg == '0);
        w_phase_nxt = r_phase;
        w_seg_nxt   = r_seg - 1'b1;
        w_pos_nxt   = (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
        if (w_seg_done) begin
            case (r_phase)
                ACTIVE: begin w_phase_nxt = FRONT;  w_seg_nxt = LAST_FP;     end
                FRONT:  begin w_phase_nxt = SYNC;   w_seg_nxt = LAST_SYNC;   end
                SYNC:   begin w_phase_nxt = BACK;   w_seg_nxt = LAST_BP;     end
                default: begin w_phase_nxt = ACTIVE; w_seg_nxt = LAST_ACTIVE; end
            endcase
        end
    end

    // Outputs.
    always_comb begin
        o_phase = r_phase;
        o_pos   = r_pos;
        o_wrap  = i_adv && (r_phase == BACK) && (r_seg == '0);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster generator: syncs, display enable, pixel/scaled coordinates, pixel/line/frame strobes.
// Latency : every output is registered, one enabled cycle behind the H/V counters; outputs stay mutually aligned.
// Backpressure: en low holds all counters and outputs (strobes included, so consumers qualify with en).
// Ports   : clk, rst (async, active-high), en; hsync, vsync, de, x_pos, y_pos, x_scaled, y_scaled,
//           pix_strobe, line_start, frame_start.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   SCALE_LOG2 = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          de,
    output logic [COORD_W-1:0]            x_pos,
    output logic [COORD_W-1:0]            y_pos,
    output logic [COORD_W-SCALE_LOG2-1:0] x_scaled,
    output logic [COORD_W-SCALE_LOG2-1:0] y_scaled,
    output logic                          pix_strobe,
    output logic                          line_start,
    output logic                          frame_start
);

    generate
        if (SCALE_LOG2 < 0 || SCALE_LOG2 >= COORD_W) begin : g_bad_scale
            $error("vga_timing_gen: SCALE_LOG2 out of range");
        end
    endgenerate

    // Low SCALE_LOG2 bits of the column; zero marks the first pixel of a scaled pixel.
    localparam logic [COORD_W-1:0] SUB_MASK = COORD_W'((1 << SCALE_LOG2) - 1);

    phase_e             w_h_phase;
    phase_e             w_v_phase;
    logic [COORD_W-1:0] w_h;
    logic [COORD_W-1:0] w_v;
    logic               w_h_wrap;
    // End-of-frame marker from the vertical axis; nothing downstream consumes it.
    logic               w_v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (en),
        .o_phase (w_h_phase),
        .o_pos   (w_h),
        .o_wrap  (w_h_wrap)
    );

    // The line counter steps only when the column counter wraps (already qualified by en).
    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_h_wrap),
        .o_phase (w_v_phase),
        .o_pos   (w_v),
        .o_wrap  (w_v_wrap_unused)
    );

    // Decode from the current counters; the registers below add the one-cycle lag.
    logic               w_de;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_pix;
    logic               w_line;
    logic               w_frame;

    always_comb begin
        w_de    = (w_h_phase == ACTIVE) && (w_v_phase == ACTIVE);
        w_x     = w_de ? w_h : '0;
        w_y     = (w_v_phase == ACTIVE) ? w_v : '0;
        w_pix   = w_de && ((w_h & SUB_MASK) == '0);
        w_line  = w_de && (w_h == '0);
        w_frame = w_line && (w_v == '0);
    end

    logic                          r_hsync;
    logic                          r_vsync;
    logic                          r_de;
    logic [COORD_W-1:0]            r_x_pos;
    logic [COORD_W-1:0]            r_y_pos;
    logic [COORD_W-SCALE_LOG2-1:0] r_x_scaled;
    logic [COORD_W-SCALE_LOG2-1:0] r_y_scaled;
    logic                          r_pix_strobe;
    logic                          r_line_start;
    logic                          r_frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_x_pos       <= '0;
            r_y_pos       <= '0;
            r_x_scaled    <= '0;
            r_y_scaled    <= '0;
            r_pix_strobe  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hsync       <= (w_h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_de;
            r_x_pos       <= w_x;
            r_y_pos       <= w_y;
            r_x_scaled    <= w_x[COORD_W-1:SCALE_LOG2];
            r_y_scaled    <= w_y[COORD_W-1:SCALE_LOG2];
            r_pix_strobe  <= w_pix;
            r_line_start  <= w_line;
            r_frame_start <= w_frame;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x_pos       = r_x_pos;
    assign y_pos       = r_y_pos;
    assign x_scaled    = r_x_scaled;
    assign y_scaled    = r_y_scaled;
    assign pix_strobe  = r_pix_strobe;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the display raster that drives the shader pipeline and the Tiny VGA output PMOD.
- Produces hsync/vsync, a display-enable, full-resolution pixel coordinates, downscaled shader coordinates, and per-pixel/line/frame strobes.
- Sits directly upstream of the shader execute stage: the execute stage starts a program run on each pixel strobe and reads the scaled x/y.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- SCALE_LOG2, 2, log2 of the downscale factor for the shader coordinates

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  advance enable; while low, all state and outputs hold
- hsync  out  1  horizontal sync, level set by SYNC_POL
- vsync  out  1  vertical sync, level set by SYNC_POL
- de  out  1  high during the visible area
- x_pos  out  10  current pixel column; 0 when de=0
- y_pos  out  10  current line; 0 when outside the visible lines
- x_scaled  out  10-SCALE_LOG2  x_pos >> SCALE_LOG2
- y_scaled  out  10-SCALE_LOG2  y_pos >> SCALE_LOG2
- pix_strobe  out  1  one-cycle pulse at the first pixel of each scaled pixel while de=1
- line_start  out  1  one-cycle pulse on pixel 0 of every visible line
- frame_start  out  1  one-cycle pulse on pixel (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each phase lasts its parameter length in enabled cycles.
  - A segment counter is loaded with length-1 on each phase entry and leaves the phase at 0.
  - A column counter h (0..H_TOTAL-1) runs alongside it and wraps to 0.
- Vertical phase FSM has the same four states. It advances only on the cycle where h wraps (end of BACK), using a line counter v (0..V_TOTAL-1) that wraps to 0.
- Output timing:
  - All outputs are registered and decoded from (h, v, phases) before they advance.
  - Outputs therefore lag the counters by one enabled cycle and stay mutually aligned.
- Reset (async assert):
  - Counters go to 0; both FSMs go to ACTIVE.
  - hsync/vsync go to inactive level (~SYNC_POL); de, strobes and coordinates go to 0.
  - The first enabled edge after deassertion presents pixel (0,0): de=1, frame_start=1, line_start=1, pix_strobe=1.
- hsync is active exactly while the H FSM is in SYNC (h in 656..751). vsync is active while the V FSM is in SYNC (v in 490..491), for whole lines including blanking pixels.
- de = (H FSM in ACTIVE) and (V FSM in ACTIVE).
- pix_strobe = de and x_pos[SCALE_LOG2-1:0]==0. This gives 160 strobes per visible line at the defaults.
- en=0: no counter, FSM or output register changes. Strobes are held, so the consumer must qualify them with en.
- Reset mid-frame restarts from (0,0) on the next enabled edge; no partial-line state is kept.
- Parameter legality: every phase length >= 1, and H_TOTAL, V_TOTAL <= 1024. Violations are elaborate-time errors.

Decomposition:
- vga_timing_pkg holds the default timing constants (640x480@60), the phase enum {ACTIVE, FRONT, SYNC, BACK}, and the coordinate width localparam.
- One sub-module, vga_axis_counter, is instantiated twice (H and V). It contains the phase FSM, the segment counter, the position counter, an advance input, and a wrap output.

Test Plan:
- Reset held, then released with en=1: the first edge shows de=1, frame_start=1, x_pos=0, y_pos=0, hsync=vsync=1; hsync falls on the 657th output cycle and stays low for 96 cycles.
- Line length: consecutive line_start pulses are 800 cycles apart; de is high for exactly 640 cycles per line; pix_strobe pulses 160 times per line with x_scaled 0..159 incrementing every 4 cycles.
- Frame: frame_start pulses are 420000 cycles apart; vsync is low for 1600 consecutive cycles beginning at line 490, pixel 0; y_scaled reaches 119 and de=0 for lines 480..524.
- en toggled 1/0 every other cycle: all outputs hold during en=0; sync timing in enabled-cycle counts matches the previous scenario.
- rst pulsed asynchronously at line 300, pixel 400: outputs go to reset values immediately without a clock; after release the next frame_start comes on the first enabled edge.
- Parameter override H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, SCALE_LOG2=1: line period 14, frame period 98, 4 pix_strobes per line.
